// File: rtl/irig_b_pkg.sv
// Shared constants and types for the IRIG-B (B00x) transmit encoder:
// frame layout, marker positions, FSM states and symbol kinds.
package irig_b_pkg;

  localparam int FRAME_BITS  = 100;
  localparam int NUM_MARKERS = 11;
  localparam int MARKER_POS [NUM_MARKERS] = '{0, 9, 19, 29, 39, 49, 59, 69, 79, 89, 99};

  function automatic logic [FRAME_BITS-1:0] build_marker_mask();
    logic [FRAME_BITS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_MARKERS; i++) m[MARKER_POS[i]] = 1'b1;
    return m;
  endfunction

  localparam logic [FRAME_BITS-1:0] MARKER_MASK = build_marker_mask();

  // LSB-first bit offsets of each BCD digit / binary field within the frame
  localparam int SEC_UNITS_OFS  = 1;
  localparam int SEC_TENS_OFS   = 6;
  localparam int MIN_UNITS_OFS  = 10;
  localparam int MIN_TENS_OFS   = 15;
  localparam int HOUR_UNITS_OFS = 20;
  localparam int HOUR_TENS_OFS  = 25;
  localparam int DAY_UNITS_OFS  = 30;
  localparam int DAY_TENS_OFS   = 35;
  localparam int DAY_HUND_OFS   = 40;
  localparam int YEAR_UNITS_OFS = 50;
  localparam int YEAR_TENS_OFS  = 55;
  localparam int CTRL_LO_OFS    = 60;
  localparam int CTRL_HI_OFS    = 70;
  localparam int SBS_LO_OFS     = 80;
  localparam int SBS_HI_OFS     = 90;

  typedef enum logic [2:0] {IDLE, WAIT, LOAD, SYM, END} state_t;
  typedef enum logic [1:0] {SYM_P, SYM_1, SYM_0} sym_t;

  typedef struct packed {
    logic [6:0]  sec_bcd;
    logic [6:0]  min_bcd;
    logic [5:0]  hour_bcd;
    logic [9:0]  day_bcd;
    logic [7:0]  year_bcd;
    logic [17:0] ctrl;
    logic [16:0] sbs;
  } time_fields_t;

endpackage

// File: rtl/irig_b_tx_encoder_if.sv
// Time-field write bus from the time-keeping core into the IRIG-B encoder.
interface irig_b_tx_encoder_if;
  logic        tm_wr;
  logic [6:0]  sec_bcd;
  logic [6:0]  min_bcd;
  logic [5:0]  hour_bcd;
  logic [9:0]  day_bcd;
  logic [7:0]  year_bcd;
  logic [17:0] ctrl;
  logic [16:0] sbs;

  modport master (output tm_wr, sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd, ctrl, sbs);
  modport slave  (input  tm_wr, sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd, ctrl, sbs);
endinterface

// File: rtl/irig_b_frame_map.sv
// Combinational placement of the time/control fields into the 100 data bits
// of an IRIG-B frame; marker positions are left at 0 and handled by the top.
module irig_b_frame_map
  import irig_b_pkg::*;
(
  input  time_fields_t            fields,
  output logic [FRAME_BITS-1:0]   data
);

  always_comb begin
    // NOTE: default every bit first so no path through the block leaves data unassigned (no latch).
    data = '0;
    data[SEC_UNITS_OFS  +: 4] = fields.sec_bcd[3:0];
    data[SEC_TENS_OFS   +: 3] = fields.sec_bcd[6:4];
    data[MIN_UNITS_OFS  +: 4] = fields.min_bcd[3:0];
    data[MIN_TENS_OFS   +: 3] = fields.min_bcd[6:4];
    data[HOUR_UNITS_OFS +: 4] = fields.hour_bcd[3:0];
    data[HOUR_TENS_OFS  +: 2] = fields.hour_bcd[5:4];
    data[DAY_UNITS_OFS  +: 4] = fields.day_bcd[3:0];
    data[DAY_TENS_OFS   +: 4] = fields.day_bcd[7:4];
    data[DAY_HUND_OFS   +: 2] = fields.day_bcd[9:8];
    data[YEAR_UNITS_OFS +: 4] = fields.year_bcd[3:0];
    data[YEAR_TENS_OFS  +: 4] = fields.year_bcd[7:4];
    data[CTRL_LO_OFS    +: 9] = fields.ctrl[8:0];
    data[CTRL_HI_OFS    +: 9] = fields.ctrl[17:9];
    data[SBS_LO_OFS     +: 9] = fields.sbs[8:0];
    data[SBS_HI_OFS     +: 8] = fields.sbs[16:9];
  end

endmodule

// File: rtl/irig_b_tx_encoder.sv
// IRIG-B B00x DC level-shift transmitter: latches live BCD time fields into a
// frame register and sends it as 100 PWM symbols, optionally aligned to 1PPS.
module irig_b_tx_encoder
  import irig_b_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1_250_000,
  parameter int P_HIGH       = 1_000_000,
  parameter int ONE_HIGH     = 625_000,
  parameter int ZERO_HIGH    = 250_000,
  parameter int PPS_ALIGN    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                pps,
  irig_b_tx_encoder_if.slave  tm,
  output logic                bcode_out,
  output logic                frame_start,
  output logic [6:0]          bit_idx,
  output logic                busy,
  output logic                pps_miss
);

  localparam int                CNT_W       = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  P_HIGH_C    = CNT_W'(P_HIGH);
  localparam logic [CNT_W-1:0]  ONE_HIGH_C  = CNT_W'(ONE_HIGH);
  localparam logic [CNT_W-1:0]  ZERO_HIGH_C = CNT_W'(ZERO_HIGH);
  localparam logic [6:0]        LAST_BIT    = 7'(FRAME_BITS - 1);

  if (!(0 < ZERO_HIGH && ZERO_HIGH < ONE_HIGH && ONE_HIGH < P_HIGH && P_HIGH < CLKS_PER_BIT))
  begin : g_bad_symbol_timing
    $error("irig_b_tx_encoder: need 0 < ZERO_HIGH < ONE_HIGH < P_HIGH < CLKS_PER_BIT");
  end

  state_t                  state, state_nx;
  time_fields_t            shadow, wr_fields, load_fields;
  logic [FRAME_BITS-1:0]   frame, frame_nx;
  logic [CNT_W-1:0]        cnt, high_cnt;
  sym_t                    cur_sym;
  logic                    cnt_last;

  assign wr_fields = '{sec_bcd:  tm.sec_bcd,  min_bcd:  tm.min_bcd,
                       hour_bcd: tm.hour_bcd, day_bcd:  tm.day_bcd,
                       year_bcd: tm.year_bcd, ctrl:     tm.ctrl,
                       sbs:      tm.sbs};

  // A write landing in the LOAD clock must reach this frame, so bypass the shadow.
  assign load_fields = tm.tm_wr ? wr_fields : shadow;

  irig_b_frame_map u_frame_map (
    .fields (load_fields),
    .data   (frame_nx)
  );

  assign cnt_last = (cnt == CNT_LAST);
  assign busy     = (state == LOAD) || (state == SYM) || (state == END);

  always_comb begin
    cur_sym = SYM_0;
    if (MARKER_MASK[bit_idx]) cur_sym = SYM_P;
    else if (frame[bit_idx])  cur_sym = SYM_1;
  end

  always_comb begin
    case (cur_sym)
      SYM_P:   high_cnt = P_HIGH_C;
      SYM_1:   high_cnt = ONE_HIGH_C;
      default: high_cnt = ZERO_HIGH_C;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (en) state_nx = (PPS_ALIGN != 0) ? WAIT : LOAD;
      WAIT: begin
        if (pps)      state_nx = LOAD;
        else if (!en) state_nx = IDLE;
      end
      LOAD: state_nx = SYM;
      SYM:  if (cnt_last && bit_idx == LAST_BIT) state_nx = END;
      END: begin
        if (!en)                 state_nx = IDLE;
        else if (PPS_ALIGN != 0) state_nx = WAIT;
        else                     state_nx = LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: shadow and frame registers are reset explicitly; a frame sent before any tm_wr is all-zero data.
      shadow      <= '0;
      frame       <= '0;
      cnt         <= '0;
      bit_idx     <= '0;
      bcode_out   <= 1'b0;
      frame_start <= 1'b0;
      pps_miss    <= 1'b0;
    end else begin
      bcode_out   <= 1'b0;
      frame_start <= 1'b0;
      pps_miss    <= pps && busy;
      if (tm.tm_wr) shadow <= wr_fields;
      case (state)
        LOAD: begin
          frame   <= frame_nx;
          bit_idx <= '0;
          cnt     <= '0;
        end
        SYM: begin
          // Output lags cnt by one clock, so bit 0 rises two clocks after the pps edge.
          bcode_out   <= (cnt < high_cnt);
          frame_start <= (cnt == '0) && (bit_idx == '0);
          if (cnt_last) begin
            cnt <= '0;
            if (bit_idx != LAST_BIT) bit_idx <= bit_idx + 7'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_irig_b_tx_encoder.sv
// Self-checking bench for irig_b_tx_encoder: spot-value table, full-frame pulse-width
// decode against an arithmetic frame model, and multi-cycle corner sequences.
module tb_irig_b_tx_encoder;

  localparam int CPB = 10;
  localparam int PH  = 8;
  localparam int OH  = 5;
  localparam int ZH  = 2;

  typedef struct {
    logic [6:0]  sec;
    logic [6:0]  min;
    logic [5:0]  hour;
    logic [9:0]  day;
    logic [7:0]  year;
    logic [17:0] ctrl;
    logic [16:0] sbs;
  } tf_t;

  typedef struct {
    int sel;
    int pos;
    int exp_w;
  } spot_t;

  logic       clk = 1'b0;
  logic       rst_n, en_a, en_f, pps;
  logic       bcode_a, fs_a, busy_a, miss_a;
  logic       bcode_f, fs_f, busy_f, miss_f;
  logic [6:0] bidx_a, bidx_f;

  irig_b_tx_encoder_if tm_if ();

  int checks   = 0;
  int failures = 0;
  int cap_w [100];
  int exp_w [100];
  tf_t sh_model;

  always #5 clk = ~clk;

  irig_b_tx_encoder #(
    .CLKS_PER_BIT(CPB), .P_HIGH(PH), .ONE_HIGH(OH), .ZERO_HIGH(ZH), .PPS_ALIGN(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .pps(pps), .tm(tm_if.slave),
    .bcode_out(bcode_a), .frame_start(fs_a), .bit_idx(bidx_a), .busy(busy_a), .pps_miss(miss_a)
  );

  irig_b_tx_encoder #(
    .CLKS_PER_BIT(CPB), .P_HIGH(PH), .ONE_HIGH(OH), .ZERO_HIGH(ZH), .PPS_ALIGN(0)
  ) dut_f (
    .clk(clk), .rst_n(rst_n), .en(en_f), .pps(pps), .tm(tm_if.slave),
    .bcode_out(bcode_f), .frame_start(fs_f), .bit_idx(bidx_f), .busy(busy_f), .pps_miss(miss_f)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic tf_t zero_tf();
    tf_t z;
    z.sec = '0; z.min = '0; z.hour = '0; z.day = '0; z.year = '0; z.ctrl = '0; z.sbs = '0;
    return z;
  endfunction

  task automatic drive_bus(input tf_t f);
    tm_if.sec_bcd  = f.sec;
    tm_if.min_bcd  = f.min;
    tm_if.hour_bcd = f.hour;
    tm_if.day_bcd  = f.day;
    tm_if.year_bcd = f.year;
    tm_if.ctrl     = f.ctrl;
    tm_if.sbs      = f.sbs;
  endtask

  task automatic write_fields(input tf_t f);
    drive_bus(f);
    tm_if.tm_wr = 1'b1;
    tick();
    tm_if.tm_wr = 1'b0;
    sh_model = f;
  endtask

  // Reference model: symbol high time of each of the 100 cells from the field values.
  function automatic void put_bits(input int value, input int nbits, input int pos);
    for (int k = 0; k < nbits; k++) exp_w[pos + k] = ((value >> k) & 1) != 0 ? OH : ZH;
  endfunction

  function automatic void build_expected(input tf_t f);
    for (int p = 0; p < 100; p++) exp_w[p] = ZH;
    put_bits(int'(f.sec) % 16, 4, 1);         put_bits(int'(f.sec) / 16, 3, 6);
    put_bits(int'(f.min) % 16, 4, 10);        put_bits(int'(f.min) / 16, 3, 15);
    put_bits(int'(f.hour) % 16, 4, 20);       put_bits(int'(f.hour) / 16, 2, 25);
    put_bits(int'(f.day) % 16, 4, 30);        put_bits((int'(f.day) / 16) % 16, 4, 35);
    put_bits(int'(f.day) / 256, 2, 40);
    put_bits(int'(f.year) % 16, 4, 50);       put_bits(int'(f.year) / 16, 4, 55);
    put_bits(int'(f.ctrl) % 512, 9, 60);      put_bits(int'(f.ctrl) / 512, 9, 70);
    put_bits(int'(f.sbs) % 512, 9, 80);       put_bits(int'(f.sbs) / 512, 8, 90);
    exp_w[0] = PH;
    for (int m = 9; m < 100; m += 10) exp_w[m] = PH;
  endfunction

  // Pulse pps while DUT A waits; checks the two-clock latency to frame_start/bcode_out.
  task automatic start_frame(input bit wr_in_load, input tf_t f);
    pps = 1'b1;
    tick();
    pps = 1'b0;
    if (wr_in_load) begin
      drive_bus(f);
      tm_if.tm_wr = 1'b1;
      sh_model = f;
    end
    @(negedge clk); check("lat_fs_t0", fs_a, 0);
    @(posedge clk); #1; tm_if.tm_wr = 1'b0;
    @(negedge clk); check("lat_fs_t1", fs_a, 0);
    @(negedge clk); check("lat_fs_t2", fs_a, 1);
    check("lat_bcode_t2", bcode_a, 1);
  endtask

  // Samples 1000 clocks starting at the frame_start clock; optional mid-frame stimulus.
  task automatic capture(input int pps_at, input int wr_at, input tf_t wr_f,
                         input int en_off_at, input int exp_miss);
    int miss, fs_extra, busy_lo, bidx_bad;
    miss = 0; fs_extra = 0; busy_lo = 0; bidx_bad = 0;
    for (int p = 0; p < 100; p++) cap_w[p] = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i > 0) @(negedge clk);
      pps = 1'b0;
      tm_if.tm_wr = 1'b0;
      cap_w[i / 10] += int'(bcode_a);
      if (i > 0 && fs_a) fs_extra++;
      if (miss_a) miss++;
      if (!busy_a) busy_lo++;
      if (i % 10 == 5 && int'(bidx_a) != i / 10) bidx_bad++;
      if (i == pps_at) pps = 1'b1;
      if (i == wr_at) begin
        drive_bus(wr_f);
        tm_if.tm_wr = 1'b1;
        sh_model = wr_f;
      end
      if (i == en_off_at) en_a = 1'b0;
    end
    check("cap_pps_miss_clocks", miss, exp_miss);
    check("cap_extra_frame_start", fs_extra, 0);
    check("cap_busy_low_clocks", busy_lo, 0);
    check("cap_bit_idx_errors", bidx_bad, 0);
    @(negedge clk);
    check("post_frame_busy", busy_a, 0);
    check("post_frame_bcode", bcode_a, 0);
  endtask

  task automatic compare_frame(input string tag);
    for (int p = 0; p < 100; p++)
      check($sformatf("%s_bit%0d_width", tag, p), cap_w[p], exp_w[p]);
  endtask

  task automatic wait_fs_f(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs_f && n < budget);
  endtask

  task automatic run_frame(input string tag);
    build_expected(sh_model);
    start_frame(1'b0, sh_model);
    capture(-1, -1, sh_model, -1, 0);
    compare_frame(tag);
  endtask

  initial begin
    spot_t spots[$];
    tf_t   frame_def [2];
    tf_t   f;
    int    n, cur_sel, cnt;

    // Spot values derived by hand from the frame layout.
    spots.push_back('{0, 0, PH});  spots.push_back('{0, 1, OH});  spots.push_back('{0, 2, ZH});
    spots.push_back('{0, 3, OH});  spots.push_back('{0, 4, ZH});  spots.push_back('{0, 5, ZH});
    spots.push_back('{0, 6, ZH});  spots.push_back('{0, 7, OH});  spots.push_back('{0, 8, ZH});
    spots.push_back('{0, 9, PH});
    spots.push_back('{1, 30, OH}); spots.push_back('{1, 31, ZH}); spots.push_back('{1, 35, ZH});
    spots.push_back('{1, 36, OH}); spots.push_back('{1, 40, OH}); spots.push_back('{1, 41, OH});
    spots.push_back('{1, 42, ZH}); spots.push_back('{1, 48, ZH}); spots.push_back('{1, 50, OH});
    spots.push_back('{1, 52, ZH}); spots.push_back('{1, 56, OH}); spots.push_back('{1, 60, ZH});
    spots.push_back('{1, 61, OH}); spots.push_back('{1, 70, OH}); spots.push_back('{1, 77, ZH});
    spots.push_back('{1, 78, OH}); spots.push_back('{1, 80, OH}); spots.push_back('{1, 89, PH});
    spots.push_back('{1, 97, OH}); spots.push_back('{1, 98, ZH}); spots.push_back('{1, 99, PH});

    frame_def[0] = zero_tf();
    frame_def[0].sec = 7'h25;
    frame_def[1] = zero_tf();
    frame_def[1].day  = 10'h365;
    frame_def[1].year = 8'h23;
    frame_def[1].ctrl = 18'h2AAAA;
    frame_def[1].sbs  = 17'h1FFFF;

    rst_n = 1'b0; en_a = 1'b0; en_f = 1'b0; pps = 1'b0;
    tm_if.tm_wr = 1'b0;
    drive_bus(zero_tf());
    sh_model = zero_tf();
    repeat (3) tick();
    check("reset_outputs_a", {bcode_a, fs_a, bidx_a, busy_a, miss_a}, 0);
    check("reset_outputs_f", {bcode_f, fs_f, bidx_f, busy_f, miss_f}, 0);
    rst_n = 1'b1;
    tick();

    // Free-running instance: back-to-back frames every 100*CPB+2 clocks.
    en_f = 1'b1;
    wait_fs_f(50, n);
    check("free_first_frame_start", fs_f, 1);
    wait_fs_f(1100, n);
    check("free_period_1", n, 1002);
    wait_fs_f(1100, n);
    check("free_period_2", n, 1002);
    en_f = 1'b0;
    n = 0;
    while (busy_f && n < 1100) begin
      @(negedge clk);
      n++;
    end
    check("free_stop_busy", busy_f, 0);
    check("free_stop_bcode", bcode_f, 0);

    // PPS-aligned instance idles in WAIT until pps.
    en_a = 1'b1;
    repeat (3) tick();
    check("wait_busy", busy_a, 0);
    check("wait_bcode", bcode_a, 0);

    cur_sel = -1;
    foreach (spots[i]) begin
      if (spots[i].sel != cur_sel) begin
        cur_sel = spots[i].sel;
        write_fields(frame_def[cur_sel]);
        run_frame($sformatf("table_frame%0d", cur_sel));
      end
      check($sformatf("spot_f%0d_bit%0d", spots[i].sel, spots[i].pos),
            cap_w[spots[i].pos], spots[i].exp_w);
    end

    // pps arriving mid-frame: one pps_miss clock, frame unaffected.
    build_expected(sh_model);
    start_frame(1'b0, sh_model);
    capture(500, -1, sh_model, -1, 1);
    compare_frame("pps_mid");

    // Shadow write mid-frame: old minutes now, new minutes next frame.
    f = sh_model;
    f.min = 7'h59;
    build_expected(sh_model);
    start_frame(1'b0, sh_model);
    capture(-1, 300, f, -1, 0);
    compare_frame("wr_mid_old");
    run_frame("wr_mid_new");
    check("wr_mid_new_min_units_bit0", cap_w[10], OH);

    // Write coincident with LOAD takes effect in the same frame.
    f = sh_model;
    f.min  = 7'h42;
    f.hour = 6'h17;
    build_expected(f);
    start_frame(1'b1, f);
    capture(-1, -1, f, -1, 0);
    compare_frame("wr_in_load");

    for (int r = 0; r < 3; r++) begin
      f.sec  = 7'($urandom);  f.min  = 7'($urandom); f.hour = 6'($urandom);
      f.day  = 10'($urandom); f.year = 8'($urandom); f.ctrl = 18'($urandom);
      f.sbs  = 17'($urandom);
      write_fields(f);
      run_frame($sformatf("rand%0d", r));
    end

    // en dropped at bit 40: frame completes, then IDLE ignores pps.
    build_expected(sh_model);
    start_frame(1'b0, sh_model);
    capture(-1, -1, sh_model, 400, 0);
    compare_frame("en_drop");
    pps = 1'b1;
    tick();
    pps = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (fs_a || busy_a) cnt++;
    end
    check("idle_ignores_pps", cnt, 0);

    // Asynchronous reset at bit 20.
    en_a = 1'b1;
    repeat (3) tick();
    start_frame(1'b0, sh_model);
    repeat (200) @(negedge clk);
    check("pre_reset_bit_idx", bidx_a, 20);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {bcode_a, fs_a, bidx_a, busy_a, miss_a}, 0);
    tick();
    rst_n = 1'b1;
    sh_model = zero_tf();
    repeat (3) tick();
    run_frame("post_reset_zero_shadow");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irig_b_tx_encoder.md
Name: irig_b_tx_encoder

Overview:
- Parametrised IRIG-B (B00x, DC level-shift) frame generator. Builds the 100-bit frame in hardware from live BCD time/control fields; nothing comes from a fixed ROM.
- Emits one PWM symbol per bit at a configurable clock rate.
- Frames are optionally aligned to an external 1PPS.
- Sits between the time-keeping core (field source) and the B-code output pin / UART reporting path.

Parameters:
- CLKS_PER_BIT, 1_250_000: clocks per 10 ms bit cell (125 MHz).
- P_HIGH, 1_000_000: high clocks for a marker symbol (8 ms).
- ONE_HIGH, 625_000: high clocks for a "1" symbol (5 ms).
- ZERO_HIGH, 250_000: high clocks for a "0" symbol (2 ms).
- PPS_ALIGN, 1: 1 means each frame waits for pps; 0 means frames are back-to-back, free-running.

Ports:
- clk in 1: system clock.
- rst_n in 1: asynchronous, active-low reset.
- en in 1: run enable (level).
- pps in 1: 1-clock pulse, already synchronised to clk.
- tm_wr in 1: write strobe for the shadow field registers.
- sec_bcd in 7: seconds BCD, tens[6:4], units[3:0].
- min_bcd in 7: minutes BCD.
- hour_bcd in 6: hours BCD.
- day_bcd in 10: day-of-year BCD, hundreds[9:8].
- year_bcd in 8: year BCD.
- ctrl in 18: control-function bits.
- sbs in 17: straight-binary seconds of day.
- bcode_out out 1: B-code level.
- frame_start out 1: 1-clock pulse on the first high clock of bit 0.
- bit_idx out 7: index of the bit currently being sent, 0..99.
- busy out 1: high while a frame is in progress.
- pps_miss out 1: 1-clock pulse when pps arrives during a frame.

Behaviour:
- Reset values: all outputs 0, state IDLE, shadow registers and frame register 0.
- State IDLE
  - en=1 and PPS_ALIGN=1 -> WAIT.
  - en=1 and PPS_ALIGN=0 -> LOAD.
- State WAIT
  - bcode_out=0.
  - pps=1 -> LOAD.
  - en=0 -> IDLE.
- State LOAD (1 clock)
  - Frame register <= frame_map(shadow); bit_idx <= 0; cnt <= 0 -> SYM.
  - If tm_wr is high in the same clock, the new port values are used (bypass).
- State SYM
  - cnt runs 0..CLKS_PER_BIT-1.
  - bcode_out (registered) = 1 when cnt < HIGH of the current symbol, else 0.
  - HIGH is P_HIGH for marker positions, ONE_HIGH for data 1, ZERO_HIGH for data 0.
  - At cnt = CLKS_PER_BIT-1 and bit_idx < 99: bit_idx++, cnt <= 0, stay in SYM.
  - At cnt = CLKS_PER_BIT-1 and bit_idx = 99 -> END.
- State END (1 clock)
  - en=0 -> IDLE.
  - PPS_ALIGN=1 -> WAIT.
  - Otherwise -> LOAD.
  - Free-running period is therefore 100*CLKS_PER_BIT+2 clocks.
- Latency: pps seen in WAIT at clock t gives bcode_out=1 and frame_start=1 at t+2.
- busy is 1 in LOAD, SYM and END.
- pps_miss fires when pps=1 in LOAD, SYM or END. That pps is otherwise ignored and causes no resync.
- Dropping en mid-frame does not truncate: the current frame completes, then the block goes to IDLE with bcode_out=0.
- rst_n low mid-frame: immediate asynchronous return to reset values.
- Shadow registers load on any tm_wr. Only LOAD copies them into the frame register, so a mid-frame write never corrupts the frame being sent.
- Frame map (LSB-first BCD, unlisted positions = 0):
  - Markers at 0, 9, 19, 29, 39, 49, 59, 69, 79, 89, 99.
  - Seconds: units 1-4, tens 6-8.
  - Minutes: units 10-13, tens 15-17.
  - Hours: units 20-23, tens 25-26.
  - Day: units 30-33, tens 35-38, hundreds 40-41.
  - Year: units 50-53, tens 55-58.
  - ctrl[8:0] at 60-68, ctrl[17:9] at 70-78.
  - sbs[8:0] at 80-88, sbs[16:9] at 90-97.
- Counter width is $clog2(CLKS_PER_BIT).
- Elaboration check: every *_HIGH is greater than 0 and less than CLKS_PER_BIT, and ZERO_HIGH < ONE_HIGH < P_HIGH.

Decomposition:
- Package irig_b_pkg holds:
  - the marker position list and 100-bit marker mask;
  - the field offset constants;
  - the state enum (IDLE, WAIT, LOAD, SYM, END);
  - the symbol-type enum (SYM_P, SYM_1, SYM_0).
- One combinational sub-module, irig_b_frame_map: field inputs -> data[99:0]. Marker handling stays in the top level via the package mask.

Test Plan (CLKS_PER_BIT=10, P_HIGH=8, ONE_HIGH=5, ZERO_HIGH=2):
- PPS_ALIGN=1, sec=0x25, en=1, pps at t -> frame_start at t+2; bit0 is 8 high / 2 low; bits 1-4 are 1,0,1,0; bits 6-8 are 0,1,0; bit 9 is a marker.
- Full frame with day=0x365, year=0x23, ctrl=0x2AAAA, sbs=0x1FFFF -> decode bcode_out pulse widths over 100 bits and compare against the map; zero positions 42-48 and 98 carry 2-clock pulses.
- PPS_ALIGN=0 -> consecutive frame_start pulses exactly 1002 clocks apart.
- pps injected at bit 50 -> pps_miss for 1 clock; frame timing unchanged.
- tm_wr with min=0x59 at bit 30 -> current frame keeps the old minutes; the next frame carries 0x59. tm_wr coincident with LOAD -> the new value is used in the same frame.
- en=0 at bit 40 -> frame completes through bit 99, then IDLE with bcode_out=0 and busy=0. rst_n low at bit 20 -> all outputs 0 immediately.
